// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command into one APB transfer and returns a held response.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase wait limit that aborts with rsp_err.
module apb_requester #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWAKEUP,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_requester: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwakeup_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]        tmo_cnt_q;
  logic                    rsp_err_q;
`endif

  // Ready only when idle with no unconsumed response, so rsp_ready never reaches cmd_ready.
  assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q && !PRESET;

  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWAKEUP   = pwakeup_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  // Transfer sequencer: every bus and response output is a register updated here.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      pwrite_q    <= 1'b0;
      pwdata_q    <= {DATA_WIDTH{1'b0}};
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwakeup_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= {CNT_W{1'b0}};
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_wdata;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q <= {CNT_W{1'b0}};
`endif
            state_q  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          psel_q    <= 1'b1;
          penable_q <= 1'b0;
          pwakeup_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // First ACCESS cycle only raises PENABLE; PREADY counts once PENABLE is on the bus.
          if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (PREADY) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwakeup_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? {DATA_WIDTH{1'b0}} : PRDATA;
`ifdef APB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            tmo_cnt_q   <= {CNT_W{1'b0}};
`endif
            state_q     <= ST_IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt_q == CNT_LAST) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwakeup_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            rsp_err_q   <= 1'b1;
            tmo_cnt_q   <= {CNT_W{1'b0}};
            state_q     <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
`endif
        end

        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          pwakeup_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
